// File: rtl/frame_update_scheduler_pkg.sv
// Shared game definitions: phase codes, plot-port owner codes and frame timing.
`default_nettype none

package frame_update_scheduler_pkg;

  typedef enum logic [2:0] {
    PH_IDLE        = 3'd0,
    PH_ERASE_BIRD  = 3'd1,
    PH_ERASE_PIPES = 3'd2,
    PH_MOVE        = 3'd3,
    PH_DRAW_PIPES  = 3'd4,
    PH_DRAW_BIRD   = 3'd5,
    PH_CHECK       = 3'd6
  } phase_t;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_BIRD  = 2'd1;
  localparam logic [1:0] OWN_PIPES = 2'd2;

  // Clock cycles per frame at 50 MHz / 60 Hz, used by the frame divider.
  localparam int unsigned FRAME_PERIOD = 833_333;

  function automatic logic [1:0] owner_of(input phase_t ph);
    case (ph)
      PH_ERASE_BIRD, PH_DRAW_BIRD:   owner_of = OWN_BIRD;
      PH_ERASE_PIPES, PH_DRAW_PIPES: owner_of = OWN_PIPES;
      default:                       owner_of = OWN_NONE;
    endcase
  endfunction

  function automatic logic is_client_phase(input phase_t ph);
    is_client_phase = (ph == PH_ERASE_BIRD) || (ph == PH_ERASE_PIPES) ||
                      (ph == PH_MOVE) || (ph == PH_DRAW_PIPES) ||
                      (ph == PH_DRAW_BIRD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_update_scheduler_timeout.sv
// Per-phase watchdog: cleared on load, counts up and flags when the limit is hit.
`default_nettype none

module phase_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_W           = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  logic [TO_W-1:0] count;

  assign expired = (count == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_update_scheduler.sv
// Per-frame phase sequencer: runs erase/move/draw/check handshakes on each frame tick
// and selects the owner of the shared VGA plot port.
`default_nettype none

module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_W           = 17
) (
  input  logic        frameClock,
  input  logic        resetLow,
  input  logic        frameTick,
  input  logic        gameRun,
  input  logic        restart,
  input  logic        phaseDone,
  input  logic        collision,
  output logic [2:0]  phase,
  output logic        phaseStart,
  output logic [1:0]  vgaOwner,
  output logic        busy,
  output logic        gameOver,
  output logic        errTimeout,
  output logic [7:0]  overrunCount,
  output logic [15:0] frameCount
);

  phase_t      state, state_next;
  logic        start_pulse, start_next;
  logic        pending, pending_next;
  logic        game_over, game_over_next;
  logic        err_to, err_next;
  logic [7:0]  overrun, overrun_next;
  logic [15:0] frame_cnt, frame_next;

  logic tick_ok;
  logic honoured;
  logic to_load;
  logic to_expired;

  phase_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk     (frameClock),
    .rst_n   (resetLow),
    .load    (to_load),
    .expired (to_expired)
  );

  assign tick_ok  = frameTick && gameRun && !game_over;
  // A done coincident with the start pulse belongs to the previous phase's client.
  assign honoured = phaseDone && !start_pulse;

  always_comb begin
    state_next     = state;
    pending_next   = pending;
    game_over_next = game_over;
    err_next       = err_to;
    overrun_next   = overrun;
    frame_next     = frame_cnt;

    if (restart) begin
      state_next     = PH_IDLE;
      pending_next   = 1'b0;
      game_over_next = 1'b0;
      err_next       = 1'b0;
      overrun_next   = '0;
    end else begin
      case (state)
        PH_IDLE: begin
          if (tick_ok) state_next = PH_ERASE_BIRD;
        end
        PH_ERASE_BIRD, PH_ERASE_PIPES, PH_MOVE, PH_DRAW_PIPES, PH_DRAW_BIRD: begin
          if (tick_ok) begin
            if (!pending) pending_next = 1'b1;
            else if (overrun != 8'hFF) overrun_next = overrun + 8'd1;
          end
          if (to_expired) err_next = 1'b1;
          // Client phase codes are contiguous, so the successor is code + 1.
          if (honoured || to_expired) state_next = phase_t'(state + 3'd1);
        end
        PH_CHECK: begin
          frame_next   = frame_cnt + 16'd1;
          pending_next = 1'b0;
          if (collision) game_over_next = 1'b1;
          if (tick_ok && pending && overrun != 8'hFF) overrun_next = overrun + 8'd1;
          if (((pending && gameRun) || tick_ok) && !collision) state_next = PH_ERASE_BIRD;
          else                                                 state_next = PH_IDLE;
        end
        default: state_next = PH_IDLE;
      endcase
    end
  end

  assign start_next = (state_next != state) && is_client_phase(state_next);
  assign to_load    = (state_next != state) || !is_client_phase(state);

  always_ff @(posedge frameClock or negedge resetLow) begin
    if (!resetLow) begin
      state       <= PH_IDLE;
      start_pulse <= 1'b0;
      pending     <= 1'b0;
      game_over   <= 1'b0;
      err_to      <= 1'b0;
      overrun     <= '0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_next;
      start_pulse <= start_next;
      pending     <= pending_next;
      game_over   <= game_over_next;
      err_to      <= err_next;
      overrun     <= overrun_next;
      frame_cnt   <= frame_next;
    end
  end

  assign phase        = state;
  assign phaseStart   = start_pulse;
  assign vgaOwner     = owner_of(state);
  assign busy         = (state != PH_IDLE);
  assign gameOver     = game_over;
  assign errTimeout   = err_to;
  assign overrunCount = overrun;
  assign frameCount   = frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_frame_update_scheduler.sv
// Directed self-checking bench for frame_update_scheduler.
`default_nettype none
`timescale 1ns/1ps

module tb_frame_update_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tick, run, restart, done, coll;
  logic [2:0]  phase;
  logic        start, busy, over, err;
  logic [1:0]  owner;
  logic [7:0]  ovr;
  logic [15:0] fcnt;

  logic        t_rst_n, t_tick, t_run, t_restart, t_done, t_coll;
  logic [2:0]  t_phase;
  logic        t_start, t_busy, t_over, t_err;
  logic [1:0]  t_owner;
  logic [7:0]  t_ovr;
  logic [15:0] t_fcnt;

  int checks = 0;
  int errors = 0;

  frame_update_scheduler dut (
    .frameClock(clk), .resetLow(rst_n), .frameTick(tick), .gameRun(run),
    .restart(restart), .phaseDone(done), .collision(coll),
    .phase(phase), .phaseStart(start), .vgaOwner(owner), .busy(busy),
    .gameOver(over), .errTimeout(err), .overrunCount(ovr), .frameCount(fcnt)
  );

  frame_update_scheduler #(.TIMEOUT_CYCLES(8), .TO_W(17)) dut_to (
    .frameClock(clk), .resetLow(t_rst_n), .frameTick(t_tick), .gameRun(t_run),
    .restart(t_restart), .phaseDone(t_done), .collision(t_coll),
    .phase(t_phase), .phaseStart(t_start), .vgaOwner(t_owner), .busy(t_busy),
    .gameOver(t_over), .errTimeout(t_err), .overrunCount(t_ovr), .frameCount(t_fcnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 0; run = 0; restart = 0; done = 0; coll = 0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start_frame();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Drives client dones 'delay' cycles after each start until phase returns to IDLE.
  // Phase and owner histories are packed one nibble per visited phase.
  task automatic run_frames(input int delay, input logic collide, input logic inject,
                            output logic [63:0] seq_code, output logic [63:0] own_code,
                            output int starts);
    int cd;
    logic [2:0] prev;
    cd = -1; starts = 0; seq_code = '0; own_code = '0; prev = 3'd7;
    for (int i = 0; i < 600; i++) begin
      if (phase !== prev) begin
        seq_code = (seq_code << 4) | {61'd0, phase};
        own_code = (own_code << 4) | {62'd0, owner};
        prev = phase;
      end
      if (phase == 3'd0) break;
      if (start) begin starts++; cd = delay; end
      else if (cd > 0) cd--;
      else if (cd == 0) cd = -1;
      done = (cd == 0);
      coll = collide;
      tick = inject && (i == 5 || i == 30 || i == 55);
      step();
    end
    done = 0; tick = 0; coll = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 0; run = 0; restart = 0; done = 0; coll = 0;
    step();
    checks++;
    if ({phase, start, owner, busy, over, err, ovr, fcnt} !== 33'd0) begin
      errors++;
      $display("FAIL reset_values: got %h expected 0", {phase, start, owner, busy, over, err, ovr, fcnt});
    end
    rst_n = 1'b1;
    step();
    start_frame();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL paused_tick busy: got %b expected 0", busy); end
  endtask

  task automatic test_normal_frame();
    logic [63:0] sc, oc;
    int st;
    do_reset();
    run = 1'b1;
    start_frame();
    run_frames(3, 1'b0, 1'b0, sc, oc, st);
    checks++;
    if (sc !== 64'h1234560) begin errors++; $display("FAIL normal_phase_seq: got %h expected 1234560", sc); end
    checks++;
    if (oc !== 64'h1202100) begin errors++; $display("FAIL normal_owner_seq: got %h expected 1202100", oc); end
    checks++;
    if (st !== 5) begin errors++; $display("FAIL normal_starts: got %0d expected 5", st); end
    checks++;
    if (fcnt !== 16'd1) begin errors++; $display("FAIL normal_frame_count: got %0d expected 1", fcnt); end
  endtask

  task automatic test_collision();
    logic [63:0] sc, oc;
    int st;
    do_reset();
    run = 1'b1;
    start_frame();
    run_frames(3, 1'b1, 1'b0, sc, oc, st);
    checks++;
    if (over !== 1'b1 || phase !== 3'd0) begin
      errors++; $display("FAIL collision_game_over: got over=%b phase=%0d expected over=1 phase=0", over, phase);
    end
    start_frame();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL collision_tick_ignored: got busy=%b expected 0", busy); end
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (over !== 1'b0) begin errors++; $display("FAIL restart_clears_over: got %b expected 0", over); end
    start_frame();
    checks++;
    if (phase !== 3'd1 || start !== 1'b1) begin
      errors++; $display("FAIL restart_then_start: got phase=%0d start=%b expected 1 1", phase, start);
    end
  endtask

  task automatic test_overrun();
    logic [63:0] sc, oc;
    int st;
    do_reset();
    run = 1'b1;
    start_frame();
    run_frames(20, 1'b0, 1'b1, sc, oc, st);
    checks++;
    if (sc !== 64'h1234561234560) begin errors++; $display("FAIL overrun_phase_seq: got %h expected 1234561234560", sc); end
    checks++;
    if (ovr !== 8'd2) begin errors++; $display("FAIL overrun_count: got %0d expected 2", ovr); end
    checks++;
    if (fcnt !== 16'd2) begin errors++; $display("FAIL overrun_frame_count: got %0d expected 2", fcnt); end
    checks++;
    if (st !== 10) begin errors++; $display("FAIL overrun_starts: got %0d expected 10", st); end
  endtask

  task automatic test_timeout();
    int cd, move_cycles;
    logic [2:0] after_move;
    logic err_at_exit, seen_exit;
    t_rst_n = 1'b0; t_tick = 0; t_run = 0; t_restart = 0; t_done = 0; t_coll = 0;
    step(); step();
    t_rst_n = 1'b1;
    step();
    t_run = 1'b1; t_tick = 1'b1;
    step();
    t_tick = 1'b0;
    checks++;
    if (t_err !== 1'b0) begin errors++; $display("FAIL timeout_err_initial: got %b expected 0", t_err); end
    cd = -1; move_cycles = 0; after_move = 3'd0; err_at_exit = 1'b0; seen_exit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (t_phase == 3'd3) move_cycles++;
      else if (move_cycles > 0 && !seen_exit) begin
        seen_exit = 1'b1; after_move = t_phase; err_at_exit = t_err;
      end
      if (t_phase == 3'd0) break;
      if (t_start) cd = 3;
      else if (cd > 0) cd--;
      else if (cd == 0) cd = -1;
      t_done = (cd == 0) && (t_phase != 3'd3);
      step();
    end
    t_done = 1'b0;
    checks++;
    if (move_cycles !== 9) begin errors++; $display("FAIL timeout_move_len: got %0d expected 9", move_cycles); end
    checks++;
    if (after_move !== 3'd4) begin errors++; $display("FAIL timeout_next_phase: got %0d expected 4", after_move); end
    checks++;
    if (err_at_exit !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b expected 1", err_at_exit); end
    checks++;
    if (t_err !== 1'b1 || t_phase !== 3'd0 || t_fcnt !== 16'd1) begin
      errors++; $display("FAIL timeout_sticky: got err=%b phase=%0d frames=%0d expected 1 0 1", t_err, t_phase, t_fcnt);
    end
  endtask

  task automatic test_done_in_start();
    do_reset();
    run = 1'b1;
    start_frame();
    step(); step();
    done = 1'b1;
    step();
    checks++;
    if (phase !== 3'd2 || start !== 1'b1) begin
      errors++; $display("FAIL dis_enter_pipes: got phase=%0d start=%b expected 2 1", phase, start);
    end
    step();
    done = 1'b0;
    checks++;
    if (phase !== 3'd2) begin errors++; $display("FAIL dis_ignored: got phase=%0d expected 2", phase); end
    step();
    checks++;
    if (phase !== 3'd2) begin errors++; $display("FAIL dis_holds: got phase=%0d expected 2", phase); end
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (phase !== 3'd3 || start !== 1'b1) begin
      errors++; $display("FAIL dis_later_done: got phase=%0d start=%b expected 3 1", phase, start);
    end
  endtask

  task automatic go_to_phase(input logic [2:0] target);
    for (int i = 0; i < 50; i++) begin
      if (phase == target) break;
      done = !start;
      tick = (i == 1 || i == 2);
      step();
    end
    done = 1'b0; tick = 1'b0;
  endtask

  task automatic test_abort();
    logic [63:0] sc, oc;
    int st;
    do_reset();
    run = 1'b1;
    start_frame();
    go_to_phase(3'd4);
    checks++;
    if (phase !== 3'd4 || ovr !== 8'd1) begin
      errors++; $display("FAIL abort_setup: got phase=%0d ovr=%0d expected 4 1", phase, ovr);
    end
    restart = 1'b1; tick = 1'b1; done = 1'b1;
    step();
    restart = 1'b0; tick = 1'b0; done = 1'b0;
    checks++;
    if ({phase, owner, start, busy, ovr} !== 15'd0) begin
      errors++; $display("FAIL abort_idle: got phase=%0d owner=%0d start=%b busy=%b ovr=%0d expected all 0",
                         phase, owner, start, busy, ovr);
    end
    step();
    checks++;
    if (phase !== 3'd0) begin errors++; $display("FAIL abort_stays_idle: got %0d expected 0", phase); end
    start_frame();
    run_frames(3, 1'b0, 1'b0, sc, oc, st);
    checks++;
    if (sc !== 64'h1234560) begin errors++; $display("FAIL abort_no_pending: got %h expected 1234560", sc); end
  endtask

  task automatic test_async_reset();
    logic [63:0] sc, oc;
    int st;
    do_reset();
    run = 1'b1;
    start_frame();
    run_frames(3, 1'b0, 1'b0, sc, oc, st);
    start_frame();
    go_to_phase(3'd3);
    step();
    checks++;
    if (phase !== 3'd3 || fcnt !== 16'd1 || ovr !== 8'd1) begin
      errors++; $display("FAIL midmove_setup: got phase=%0d frames=%0d ovr=%0d expected 3 1 1", phase, fcnt, ovr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({phase, start, owner, busy, over, err, ovr, fcnt} !== 33'd0) begin
      errors++; $display("FAIL async_reset_values: got %h expected 0", {phase, start, owner, busy, over, err, ovr, fcnt});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t_rst_n = 1'b0; t_tick = 0; t_run = 0; t_restart = 0; t_done = 0; t_coll = 0;
    #1;
    test_reset();
    test_normal_frame();
    test_collision();
    test_overrun();
    test_timeout();
    test_done_in_start();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
